can_tx_scheduler: RTL and testbench

Transmit mailbox scheduler for the CAN controller. It holds NUM_MB standard-frame mailboxes (11-bit ID, DLC, 64-bit data) and picks the highest-priority pending one, which is the lowest ID. It presents the chosen frame to the bit-level transmit engine through a req/ack handshake, then handles completion, lost arbitration, error retry and abort.

---
 rtl/can_tx_scheduler_if.sv | 39 +++
 rtl/can_tx_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_scheduler_if.sv
// Host/engine-facing signal bundle of can_tx_scheduler: mailbox load/abort,
// frame hand-off to the bit engine, and per-mailbox status.
interface can_tx_scheduler_if #(
  parameter int NUM_MB   = 4,
  parameter int MB_IDX_W = $clog2(NUM_MB)
);
  logic                wr_en;
  logic [MB_IDX_W-1:0] wr_mb;
  logic [10:0]         wr_id;
  logic [3:0]          wr_dlc;
  logic [63:0]         wr_data;
  logic                wr_rej;
  logic                abort_en;
  logic [MB_IDX_W-1:0] abort_mb;
  logic                tx_req;
  logic [10:0]         tx_id;
  logic [3:0]          tx_dlc;
  logic [63:0]         tx_data;
  logic                tx_ack;
  logic                tx_done;
  logic                tx_arb_lost;
  logic                tx_error;
  logic [NUM_MB-1:0]   mb_pending;
  logic [NUM_MB-1:0]   mb_done;
  logic [NUM_MB-1:0]   mb_fail;
  logic                busy;

  modport master (
    output wr_en, wr_mb, wr_id, wr_dlc, wr_data, abort_en, abort_mb,
           tx_ack, tx_done, tx_arb_lost, tx_error,
    input  wr_rej, tx_req, tx_id, tx_dlc, tx_data, mb_pending, mb_done, mb_fail, busy
  );

  modport slave (
    input  wr_en, wr_mb, wr_id, wr_dlc, wr_data, abort_en, abort_mb,
           tx_ack, tx_done, tx_arb_lost, tx_error,
    output wr_rej, tx_req, tx_id, tx_dlc, tx_data, mb_pending, mb_done, mb_fail, busy
  );
endinterface

// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: lowest-ID selection (oldest-first when
// CAN_TXSCHED_FIFO_ORDER_EN is defined), req/ack hand-off, retry and abort.
module can_tx_scheduler #(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 3
) (
  input logic               clk,
  input logic               rst,
  can_tx_scheduler_if.slave bus
);
  localparam int MB_IDX_W = $clog2(NUM_MB);

  typedef enum logic [1:0] {IDLE, SELECT, REQ, ACTIVE} state_e;

  state_e                  state_q, state_d;
  logic [NUM_MB-1:0]       pend_q, pend_d, done_q, done_d, fail_q, fail_d;
  logic [NUM_MB-1:0][3:0]  retry_q, retry_d;
  logic [NUM_MB-1:0][10:0] id_q;
  logic [NUM_MB-1:0][3:0]  dlc_q;
  logic [NUM_MB-1:0][63:0] data_q;
  logic [MB_IDX_W-1:0]     sel_q, sel_d;
  logic                    aflag_q, aflag_d, rej_q, rej_d;
  logic [10:0]             tx_id_q, tx_id_d;
  logic [3:0]              tx_dlc_q, tx_dlc_d;
  logic [63:0]             tx_data_q, tx_data_d;

  logic                    ld_ok, ab_in, ab_hit, ab_sel, aflag_eff, best_vld;
  logic [MB_IDX_W-1:0]     best_idx;
  logic [NUM_MB-1:0]       cand;
`ifdef CAN_TXSCHED_FIFO_ORDER_EN
  logic [7:0]              seq_q, best_age, age;
  logic [NUM_MB-1:0][7:0]  stamp_q;
`else
  logic [10:0]             best_id;
`endif

  always_comb begin
    ab_in  = 32'(bus.abort_mb) < NUM_MB;
    ab_hit = bus.abort_en && ab_in && pend_q[bus.abort_mb];
    // The in-flight mailbox is only flagged (ACTIVE) or dropped via the REQ path.
    ab_sel = ab_hit && (bus.abort_mb == sel_q) && (state_q == REQ || state_q == ACTIVE);
    ld_ok  = bus.wr_en && (32'(bus.wr_mb) < NUM_MB) && !pend_q[bus.wr_mb] &&
             !(bus.abort_en && bus.abort_mb == bus.wr_mb);
  end

  // A mailbox being aborted this cycle is not a selection candidate.
  always_comb begin
    cand = pend_q;
    if (bus.abort_en && ab_in) cand[bus.abort_mb] = 1'b0;
    best_vld = 1'b0;
    best_idx = '0;
`ifdef CAN_TXSCHED_FIFO_ORDER_EN
    best_age = '0;
    age      = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      age = seq_q - stamp_q[i];
      if (cand[i] && (!best_vld || age > best_age)) begin
        best_vld = 1'b1;
        best_idx = MB_IDX_W'(i);
        best_age = age;
      end
    end
`else
    best_id = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (cand[i] && (!best_vld || id_q[i] < best_id)) begin
        best_vld = 1'b1;
        best_idx = MB_IDX_W'(i);
        best_id  = id_q[i];
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    retry_d   = retry_q;
    sel_d     = sel_q;
    aflag_d   = aflag_q;
    tx_id_d   = tx_id_q;
    tx_dlc_d  = tx_dlc_q;
    tx_data_d = tx_data_q;
    done_d    = '0;
    fail_d    = '0;
    rej_d     = bus.wr_en && !ld_ok;
    aflag_eff = aflag_q || ab_sel;

    if (ab_hit && !ab_sel) begin
      pend_d[bus.abort_mb] = 1'b0;
      fail_d[bus.abort_mb] = 1'b1;
    end

    unique case (state_q)
      IDLE: if (|pend_q) state_d = SELECT;
      SELECT: begin
        if (best_vld) begin
          sel_d     = best_idx;
          tx_id_d   = id_q[best_idx];
          tx_dlc_d  = dlc_q[best_idx];
          tx_data_d = data_q[best_idx];
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.tx_ack) begin
          state_d = ACTIVE;
          aflag_d = ab_sel;
        end else if (ab_sel) begin
          pend_d[sel_q] = 1'b0;
          fail_d[sel_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      ACTIVE: begin
        if (ab_sel) aflag_d = 1'b1;
        if (bus.tx_done || bus.tx_error || bus.tx_arb_lost) begin
          state_d = IDLE;
          aflag_d = 1'b0;
          if (bus.tx_done) begin
            pend_d[sel_q] = 1'b0;
            done_d[sel_q] = 1'b1;
          end else if (bus.tx_error) begin
            retry_d[sel_q] = retry_q[sel_q] + 4'd1;
            if (({1'b0, retry_q[sel_q]} + 5'd1 == 5'(MAX_RETRY)) || aflag_eff) begin
              pend_d[sel_q] = 1'b0;
              fail_d[sel_q] = 1'b1;
            end
          end else if (aflag_eff) begin
            pend_d[sel_q] = 1'b0;
            fail_d[sel_q] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (ld_ok) begin
      pend_d[bus.wr_mb]  = 1'b1;
      retry_d[bus.wr_mb] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      done_q    <= '0;
      fail_q    <= '0;
      retry_q   <= '0;
      id_q      <= '0;
      dlc_q     <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      aflag_q   <= 1'b0;
      rej_q     <= 1'b0;
      tx_id_q   <= '0;
      tx_dlc_q  <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      retry_q   <= retry_d;
      sel_q     <= sel_d;
      aflag_q   <= aflag_d;
      rej_q     <= rej_d;
      tx_id_q   <= tx_id_d;
      tx_dlc_q  <= tx_dlc_d;
      tx_data_q <= tx_data_d;
      if (ld_ok) begin
        id_q[bus.wr_mb]   <= bus.wr_id;
        dlc_q[bus.wr_mb]  <= (bus.wr_dlc > 4'd8) ? 4'd8 : bus.wr_dlc;
        data_q[bus.wr_mb] <= bus.wr_data;
      end
    end
  end

`ifdef CAN_TXSCHED_FIFO_ORDER_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q   <= '0;
      stamp_q <= '0;
    end else begin
      seq_q <= seq_q + 8'd1;
      if (ld_ok) stamp_q[bus.wr_mb] <= seq_q;
    end
  end
`endif

  assign bus.tx_req     = (state_q == REQ);
  assign bus.busy       = (state_q == ACTIVE);
  assign bus.tx_id      = tx_id_q;
  assign bus.tx_dlc     = tx_dlc_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.mb_pending = pend_q;
  assign bus.mb_done    = done_q;
  assign bus.mb_fail    = fail_q;
  assign bus.wr_rej     = rej_q;
endmodule

// File: tb/tb_can_tx_scheduler.sv
// Randomized bench for can_tx_scheduler against a transaction-level mailbox model.
module tb_can_tx_scheduler;
  localparam int NUM_MB    = 5;
  localparam int MAX_RETRY = 3;
  localparam int IW        = $clog2(NUM_MB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_tx_scheduler_if #(.NUM_MB(NUM_MB)) bus ();
  can_tx_scheduler #(.NUM_MB(NUM_MB), .MAX_RETRY(MAX_RETRY)) dut (.clk(clk), .rst(rst), .bus(bus));

  int          errors = 0;
  int          checks = 0;
  bit          m_pend  [NUM_MB];
  logic [10:0] m_id    [NUM_MB];
  logic [3:0]  m_dlc   [NUM_MB];
  logic [63:0] m_data  [NUM_MB];
  int          m_retry [NUM_MB];
  int          m_ord   [NUM_MB];
  int          ord_cnt = 0;
  int          cur     = 0;
  bit          aflag   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NUM_MB; i++) begin
      m_pend[i]  = 1'b0;
      m_retry[i] = 0;
    end
    aflag = 1'b0;
  endfunction

  // Oldest load wins in FIFO mode, otherwise lowest ID; ties to lowest index.
  function automatic int m_sel();
    int b = -1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (m_pend[i]) begin
`ifdef CAN_TXSCHED_FIFO_ORDER_EN
        if (b < 0 || m_ord[i] < m_ord[b]) b = i;
`else
        if (b < 0 || m_id[i] < m_id[b]) b = i;
`endif
      end
    end
    return b;
  endfunction

  function automatic logic [NUM_MB-1:0] m_pvec();
    logic [NUM_MB-1:0] v = '0;
    for (int i = 0; i < NUM_MB; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [10:0] rand_id();
    return ($urandom_range(0, 3) == 0) ? 11'h100 : 11'($urandom_range(0, 2047));
  endfunction

  // ctx: 0 idle, 1 frame presented (REQ), 2 frame in flight (ACTIVE)
  task automatic ops(input int ctx, input bit do_ld, input int ld_mb, input logic [10:0] id,
                     input logic [3:0] dlc, input logic [63:0] d,
                     input bit do_ab, input int ab_mb, output bit dropped);
    logic [NUM_MB-1:0] ef = '0;
    bit acc, ab_live;
    dropped = 1'b0;
    ab_live = do_ab && ab_mb < NUM_MB && m_pend[ab_mb];
    acc     = do_ld && ld_mb < NUM_MB && !m_pend[ld_mb] && !(do_ab && ab_mb == ld_mb);
    bus.wr_en    = do_ld;
    bus.wr_mb    = IW'(ld_mb);
    bus.wr_id    = id;
    bus.wr_dlc   = dlc;
    bus.wr_data  = d;
    bus.abort_en = do_ab;
    bus.abort_mb = IW'(ab_mb);
    step();
    bus.wr_en    = 1'b0;
    bus.abort_en = 1'b0;
    if (ab_live) begin
      if (ctx == 2 && ab_mb == cur) aflag = 1'b1;
      else begin
        m_pend[ab_mb] = 1'b0;
        ef[ab_mb]     = 1'b1;
        if (ctx == 1 && ab_mb == cur) dropped = 1'b1;
      end
    end
    if (acc) begin
      m_pend[ld_mb]  = 1'b1;
      m_id[ld_mb]    = id;
      m_dlc[ld_mb]   = (dlc > 4'd8) ? 4'd8 : dlc;
      m_data[ld_mb]  = d;
      m_retry[ld_mb] = 0;
      m_ord[ld_mb]   = ord_cnt++;
    end
    chk("wr_rej", bus.wr_rej, 64'(do_ld && !acc));
    chk("abort_fail", bus.mb_fail, ef);
    chk("pending", bus.mb_pending, m_pvec());
    if (ctx == 1) chk("req_hold", bus.tx_req, 64'(!dropped));
    if (ctx == 2) chk("busy_hold", bus.busy, 1);
  endtask

  task automatic load(input int mb, input logic [10:0] id, input logic [3:0] dlc);
    bit dr;
    ops(0, 1'b1, mb, id, dlc, {$urandom(), $urandom()}, 1'b0, 0, dr);
  endtask

  task automatic wait_req(output bit ok);
    int e = m_sel();
    ok = 1'b0;
    for (int n = 0; n < 12 && !bus.tx_req; n++) step();
    if (e < 0) begin
      chk("no_req", bus.tx_req, 0);
      return;
    end
    chk("req_seen", bus.tx_req, 1);
    if (bus.tx_req) begin
      ok  = 1'b1;
      cur = e;
      chk("tx_id", bus.tx_id, m_id[e]);
      chk("tx_dlc", bus.tx_dlc, m_dlc[e]);
      chk("tx_data", bus.tx_data, m_data[e]);
    end
  endtask

  task automatic ack(input bit with_abort);
    bus.tx_ack   = 1'b1;
    bus.abort_en = with_abort;
    bus.abort_mb = IW'(cur);
    step();
    bus.tx_ack   = 1'b0;
    bus.abort_en = 1'b0;
    if (with_abort) aflag = 1'b1;
    chk("ack_req_drop", bus.tx_req, 0);
    chk("ack_busy", bus.busy, 1);
    chk("ack_nofail", bus.mb_fail, 0);
    chk("ack_pending", bus.mb_pending, m_pvec());
  endtask

  task automatic complete(input bit dn, input bit er, input bit al);
    logic [NUM_MB-1:0] ed = '0;
    logic [NUM_MB-1:0] ef = '0;
    bus.tx_done     = dn;
    bus.tx_error    = er;
    bus.tx_arb_lost = al;
    step();
    bus.tx_done     = 1'b0;
    bus.tx_error    = 1'b0;
    bus.tx_arb_lost = 1'b0;
    if (dn) begin
      m_pend[cur] = 1'b0;
      ed[cur]     = 1'b1;
    end else if (er) begin
      m_retry[cur]++;
      if (m_retry[cur] == MAX_RETRY || aflag) begin
        m_pend[cur] = 1'b0;
        ef[cur]     = 1'b1;
      end
    end else if (aflag) begin
      m_pend[cur] = 1'b0;
      ef[cur]     = 1'b1;
    end
    aflag = 1'b0;
    chk("mb_done", bus.mb_done, ed);
    chk("mb_fail", bus.mb_fail, ef);
    chk("end_pending", bus.mb_pending, m_pvec());
    chk("end_busy", bus.busy, 0);
    step();
    chk("done_width", bus.mb_done, 0);
    chk("fail_width", bus.mb_fail, 0);
  endtask

  initial begin
    bit ok, dr;
    bit [2:0] kind;
    bus.wr_en = 0; bus.wr_mb = '0; bus.wr_id = '0; bus.wr_dlc = '0; bus.wr_data = '0;
    bus.abort_en = 0; bus.abort_mb = '0;
    bus.tx_ack = 0; bus.tx_done = 0; bus.tx_arb_lost = 0; bus.tx_error = 0;
    step(); step();
    chk("rst_req", bus.tx_req, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pend", bus.mb_pending, 0);
    chk("rst_done", bus.mb_done, 0);
    chk("rst_fail", bus.mb_fail, 0);
    chk("rst_rej", bus.wr_rej, 0);
    chk("rst_txid", bus.tx_id, 0);
    chk("rst_txdata", bus.tx_data, 0);
    rst = 1'b0;
    m_reset();

    // out-of-range mailbox is refused and starts nothing
    load(NUM_MB + 1, 11'h010, 4'd1);
    step(); step();
    chk("oor_noreq", bus.tx_req, 0);

    // lowest ID first, then the other one
    load(0, 11'h123, 4'd2);
    load(2, 11'h045, 4'd3);
    wait_req(ok);
`ifdef CAN_TXSCHED_FIFO_ORDER_EN
    chk("tp1_first", bus.tx_id, 11'h123);
`else
    chk("tp1_first", bus.tx_id, 11'h045);
`endif
    ack(0); complete(1, 0, 0);
    wait_req(ok); ack(0); complete(1, 0, 0);

    // DLC clamp, arbitration loss keeps the mailbox pending
    load(1, 11'h100, 4'd12);
    wait_req(ok);
    chk("tp2_dlc", bus.tx_dlc, 4'd8);
    ack(0); complete(0, 0, 1);
    wait_req(ok);
    chk("tp2_id", bus.tx_id, 11'h100);
    ack(0); complete(1, 0, 0);

    // retry limit
    load(3, 11'h300, 4'd4);
    repeat (MAX_RETRY) begin
      wait_req(ok); ack(0); complete(0, 1, 0);
    end
    wait_req(ok);

    // refused reload keeps stored fields; abort before ack drops the frame
    load(0, 11'h050, 4'd5);
    wait_req(ok);
    ops(1, 1'b1, 0, 11'h7AA, 4'd1, 64'hDEAD, 1'b0, 0, dr);
    ack(0); complete(0, 0, 1);
    wait_req(ok);
    chk("tp4_id", bus.tx_id, 11'h050);
    ops(1, 1'b0, 0, 11'h0, 4'd0, 64'h0, 1'b1, 0, dr);
    wait_req(ok);

    // abort while in flight: done wins, arb_lost drops
    load(4, 11'h200, 4'd6);
    wait_req(ok); ack(0);
    ops(2, 1'b0, 0, 11'h0, 4'd0, 64'h0, 1'b1, 4, dr);
    complete(1, 0, 0);
    load(4, 11'h201, 4'd6);
    wait_req(ok); ack(0);
    ops(2, 1'b0, 0, 11'h0, 4'd0, 64'h0, 1'b1, 4, dr);
    complete(0, 0, 1);

    // load and abort of the same mailbox in one cycle; ack+abort then error
    load(2, 11'h222, 4'd2);
    wait_req(ok); ack(0);
    ops(2, 1'b1, 1, 11'h111, 4'd1, 64'h1, 1'b1, 1, dr);
    complete(1, 0, 0);
    load(3, 11'h333, 4'd3);
    wait_req(ok); ack(1); complete(0, 1, 0);

    for (int r = 0; r < 150; r++) begin
      if (m_sel() < 0) begin
        load($urandom_range(0, NUM_MB - 1), rand_id(), 4'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 1)
          load($urandom_range(0, NUM_MB - 1), rand_id(), 4'($urandom_range(0, 15)));
      end
      wait_req(ok);
      if (!ok) continue;
      dr = 1'b0;
      for (int h = $urandom_range(0, 3); h > 0 && !dr; h--) begin
        case ($urandom_range(0, 3))
          0: ops(1, 1'b1, $urandom_range(0, NUM_MB - 1), rand_id(), 4'($urandom_range(0, 15)),
                 {$urandom(), $urandom()}, 1'b0, 0, dr);
          1: ops(1, 1'b0, 0, 11'h0, 4'd0, 64'h0, 1'b1, $urandom_range(0, NUM_MB - 1), dr);
          default: ops(1, 1'b0, 0, 11'h0, 4'd0, 64'h0, 1'b0, 0, dr);
        endcase
      end
      if (dr) continue;
      ack($urandom_range(0, 7) == 0);
      for (int a = $urandom_range(0, 3); a > 0; a--)
        ops(2, $urandom_range(0, 1) == 1, $urandom_range(0, NUM_MB + 2), rand_id(),
            4'($urandom_range(0, 15)), {$urandom(), $urandom()},
            $urandom_range(0, 3) == 0, $urandom_range(0, NUM_MB + 1), dr);
      kind = 3'($urandom_range(1, 7));
      complete(kind[0], kind[1], kind[2]);
    end

    // reset while a frame is in flight
    if (m_sel() < 0) load(1, 11'h0AA, 4'd2);
    wait_req(ok);
    if (ok) ack(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_reset();
    chk("rst_act_req", bus.tx_req, 0);
    chk("rst_act_busy", bus.busy, 0);
    chk("rst_act_pend", bus.mb_pending, 0);

    // arrival order vs ID order
    load(0, 11'h7FF, 4'd1);
    load(1, 11'h001, 4'd1);
    wait_req(ok);
`ifdef CAN_TXSCHED_FIFO_ORDER_EN
    chk("order_first", bus.tx_id, 11'h7FF);
`else
    chk("order_first", bus.tx_id, 11'h001);
`endif
    ack(0); complete(1, 0, 0);
    wait_req(ok); ack(0); complete(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
